// File: rtl/yuv2rgb_stream_converter_if.sv
// Pixel-in / RGB-out handshake bundle for the YUV->RGB stream converter.
// The converter sits on the slave side; the upstream/downstream driver uses master.
interface yuv2rgb_stream_converter_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] Y_in;
  logic [PIX_W-1:0] U_in;
  logic [PIX_W-1:0] V_in;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] R_out;
  logic [PIX_W-1:0] G_out;
  logic [PIX_W-1:0] B_out;

  modport slave (
    input  in_valid, Y_in, U_in, V_in, mode, out_ready,
    output in_ready, out_valid, R_out, G_out, B_out
  );

  modport master (
    output in_valid, Y_in, U_in, V_in, mode, out_ready,
    input  in_ready, out_valid, R_out, G_out, B_out
  );
endinterface

// File: rtl/yuv2rgb_stream_converter.sv
// Handshaked YUV->RGB converter: Y, V, U multiply phases on two shared multipliers,
// per-pixel studio/full-range coefficients, clipped RGB held until the consumer takes it.
module yuv2rgb_stream_converter #(
  parameter int PIX_W = 8,
  parameter int ROUND = 1
) (
  input  logic CLOCK_50_I,
  input  logic resetn,
  input  logic clear,
  yuv2rgb_stream_converter_if.slave bus
);

  localparam int OPD_W  = PIX_W + 1;
  localparam int COEF_W = 19;
  localparam int PROD_W = OPD_W + COEF_W;
  localparam int ACC_W  = PIX_W + 22;
  localparam int Q_W    = ACC_W - 16;
  localparam int SH     = PIX_W - 8;

  localparam logic signed [COEF_W-1:0] YC_STU = 19'sd76284;
  localparam logic signed [COEF_W-1:0] VR_STU = 19'sd104595;
  localparam logic signed [COEF_W-1:0] VG_STU = 19'sd53281;
  localparam logic signed [COEF_W-1:0] UG_STU = 19'sd25624;
  localparam logic signed [COEF_W-1:0] UB_STU = 19'sd132251;
  localparam logic signed [COEF_W-1:0] YC_FUL = 19'sd65536;
  localparam logic signed [COEF_W-1:0] VR_FUL = 19'sd91881;
  localparam logic signed [COEF_W-1:0] VG_FUL = 19'sd46802;
  localparam logic signed [COEF_W-1:0] UG_FUL = 19'sd22554;
  localparam logic signed [COEF_W-1:0] UB_FUL = 19'sd116130;

  localparam logic signed [OPD_W-1:0] Y_OFF_STU = OPD_W'(32'sd16 <<< SH);
  localparam logic signed [OPD_W-1:0] C_OFF     = OPD_W'(32'sd128 <<< SH);
  localparam logic signed [ACC_W-1:0] RND_ADD   = (ROUND != 0) ? ACC_W'(32'sd32768) : ACC_W'(32'sd0);
  localparam logic signed [Q_W-1:0]   Q_MAX     = Q_W'((32'sd1 <<< PIX_W) - 32'sd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_Y    = 2'd1,
    S_V    = 2'd2,
    S_U    = 2'd3
  } state_t;

  // Drop 16 fractional bits (optionally rounding half up) and clamp to the pixel range.
  function automatic logic [PIX_W-1:0] scale_clip(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] biased;
    logic signed [Q_W-1:0]   q;
    biased = acc + RND_ADD;
    q      = Q_W'(biased >>> 16);
    if (q[Q_W-1]) begin
      scale_clip = {PIX_W{1'b0}};
    end else if (q > Q_MAX) begin
      scale_clip = {PIX_W{1'b1}};
    end else begin
      scale_clip = q[PIX_W-1:0];
    end
  endfunction

  state_t                    state_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic [PIX_W-1:0]          y_r, u_r, v_r;
  logic                      mode_r;
  logic signed [ACC_W-1:0]   acc_r_r, acc_g_r, acc_b_r;
  logic [PIX_W-1:0]          r_out_r, g_out_r, b_out_r;

  logic signed [OPD_W-1:0]   y_off_s, y_opd_s, u_opd_s, v_opd_s;
  logic signed [COEF_W-1:0]  yc_s, vr_s, vg_s, ug_s, ub_s;
  logic signed [OPD_W-1:0]   opd_a_s, opd_b_s;
  logic signed [COEF_W-1:0]  coef_a_s, coef_b_s;
  logic signed [PROD_W-1:0]  prod_a_s, prod_b_s;
  logic signed [ACC_W-1:0]   fin_r_s, fin_g_s, fin_b_s;
  logic                      slot_free_s;

  // Coefficient set and signed operands for the latched pixel.
  always_comb begin
    if (mode_r) begin
      yc_s    = YC_FUL;
      vr_s    = VR_FUL;
      vg_s    = VG_FUL;
      ug_s    = UG_FUL;
      ub_s    = UB_FUL;
      y_off_s = {OPD_W{1'b0}};
    end else begin
      yc_s    = YC_STU;
      vr_s    = VR_STU;
      vg_s    = VG_STU;
      ug_s    = UG_STU;
      ub_s    = UB_STU;
      y_off_s = Y_OFF_STU;
    end
    y_opd_s = $signed({1'b0, y_r}) - y_off_s;
    u_opd_s = $signed({1'b0, u_r}) - C_OFF;
    v_opd_s = $signed({1'b0, v_r}) - C_OFF;
  end

  // Route operands to the two shared multipliers according to the active phase.
  always_comb begin
    opd_a_s  = y_opd_s;
    coef_a_s = yc_s;
    opd_b_s  = v_opd_s;
    coef_b_s = vg_s;
    case (state_r)
      S_Y: begin
        opd_a_s  = y_opd_s;
        coef_a_s = yc_s;
        opd_b_s  = v_opd_s;
        coef_b_s = vg_s;
      end
      S_V: begin
        opd_a_s  = v_opd_s;
        coef_a_s = vr_s;
        opd_b_s  = v_opd_s;
        coef_b_s = vg_s;
      end
      S_U: begin
        opd_a_s  = u_opd_s;
        coef_a_s = ug_s;
        opd_b_s  = u_opd_s;
        coef_b_s = ub_s;
      end
      default: begin
        opd_a_s  = y_opd_s;
        coef_a_s = yc_s;
        opd_b_s  = v_opd_s;
        coef_b_s = vg_s;
      end
    endcase
  end

  assign prod_a_s = PROD_W'(opd_a_s) * PROD_W'(coef_a_s);
  assign prod_b_s = PROD_W'(opd_b_s) * PROD_W'(coef_b_s);

  // The U phase is folded straight into the output load instead of taking a fourth cycle.
  assign fin_r_s = acc_r_r;
  assign fin_g_s = acc_g_r - ACC_W'(prod_a_s);
  assign fin_b_s = acc_b_r + ACC_W'(prod_b_s);

  assign slot_free_s = !out_valid_r || bus.out_ready;

  // Conversion FSM, accumulators and held output register.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      y_r         <= {PIX_W{1'b0}};
      u_r         <= {PIX_W{1'b0}};
      v_r         <= {PIX_W{1'b0}};
      mode_r      <= 1'b0;
      acc_r_r     <= {ACC_W{1'b0}};
      acc_g_r     <= {ACC_W{1'b0}};
      acc_b_r     <= {ACC_W{1'b0}};
      r_out_r     <= {PIX_W{1'b0}};
      g_out_r     <= {PIX_W{1'b0}};
      b_out_r     <= {PIX_W{1'b0}};
    end else if (clear) begin
      state_r     <= S_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            y_r        <= bus.Y_in;
            u_r        <= bus.U_in;
            v_r        <= bus.V_in;
            mode_r     <= bus.mode;
            in_ready_r <= 1'b0;
            state_r    <= S_Y;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= S_IDLE;
          end
        end
        S_Y: begin
          acc_r_r <= ACC_W'(prod_a_s);
          acc_g_r <= ACC_W'(prod_a_s);
          acc_b_r <= ACC_W'(prod_a_s);
          state_r <= S_V;
        end
        S_V: begin
          acc_r_r <= acc_r_r + ACC_W'(prod_a_s);
          acc_g_r <= acc_g_r - ACC_W'(prod_b_s);
          state_r <= S_U;
        end
        S_U: begin
          if (slot_free_s) begin
            r_out_r     <= scale_clip(fin_r_s);
            g_out_r     <= scale_clip(fin_g_s);
            b_out_r     <= scale_clip(fin_b_s);
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            state_r <= S_U;
          end
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.R_out     = r_out_r;
  assign bus.G_out     = g_out_r;
  assign bus.B_out     = b_out_r;

endmodule

// File: tb/tb_yuv2rgb_stream_converter.sv
// Directed bench for yuv2rgb_stream_converter: ROUND=1 and ROUND=0 instances in lockstep,
// an arithmetic reference model with an output scoreboard, plus literal expectations.
module tb_yuv2rgb_stream_converter;

  logic clk;
  logic resetn;
  logic clear;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  yuv2rgb_stream_converter_if #(.PIX_W(8)) ifc1 ();
  yuv2rgb_stream_converter_if #(.PIX_W(8)) ifc0 ();

  yuv2rgb_stream_converter #(.PIX_W(8), .ROUND(1)) dut1 (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .clear      (clear),
    .bus        (ifc1.slave)
  );

  yuv2rgb_stream_converter #(.PIX_W(8), .ROUND(0)) dut0 (
    .CLOCK_50_I (clk),
    .resetn     (resetn),
    .clear      (clear),
    .bus        (ifc0.slave)
  );

  typedef struct {
    int r;
    int g;
    int b;
  } rgb_t;

  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  rgb_t q1[$];
  rgb_t q0[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the colour equations evaluated with plain 64-bit integers.
  function automatic rgb_t model(input int y, input int u, input int v, input int m, input int rnd);
    longint yc, yo, vr, vg, ug, ub, ly, s;
    longint acc [3];
    int     o [3];
    rgb_t   res;
    if (m == 0) begin
      yc = 76284; yo = 16; vr = 104595; vg = 53281; ug = 25624; ub = 132251;
    end else begin
      yc = 65536; yo = 0;  vr = 91881;  vg = 46802; ug = 22554; ub = 116130;
    end
    ly     = yc * (y - yo);
    acc[0] = ly + vr * (v - 128);
    acc[1] = ly - vg * (v - 128) - ug * (u - 128);
    acc[2] = ly + ub * (u - 128);
    for (int k = 0; k < 3; k++) begin
      s    = (acc[k] + rnd * 32768) >>> 16;
      o[k] = (s < 0) ? 0 : ((s > 255) ? 255 : int'(s));
    end
    res.r = o[0];
    res.g = o[1];
    res.b = o[2];
    return res;
  endfunction

  task automatic drive_in(input logic vld, input int y, input int u, input int v, input int m);
    ifc1.in_valid = vld; ifc1.Y_in = 8'(y); ifc1.U_in = 8'(u); ifc1.V_in = 8'(v); ifc1.mode = m[0];
    ifc0.in_valid = vld; ifc0.Y_in = 8'(y); ifc0.U_in = 8'(u); ifc0.V_in = 8'(v); ifc0.mode = m[0];
  endtask

  task automatic set_ready(input logic rdy);
    ifc1.out_ready = rdy;
    ifc0.out_ready = rdy;
  endtask

  // Offer a pixel until accepted; the scoreboard learns of it after the accepting edge.
  task automatic send(input int y, input int u, input int v, input int m);
    int n = 0;
    bit ok = 1'b0;
    drive_in(1'b1, y, u, v, m);
    while (!ok && n < 50) begin
      @(negedge clk);
      if (ifc1.in_ready && !clear) ok = 1'b1;
      else n++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (ok) begin
      q1.push_back(model(y, u, v, m, 1));
      q0.push_back(model(y, u, v, m, 0));
    end
    drive_in(1'b0, 0, 0, 0, 0);
  endtask

  task automatic wait_out(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc1.out_valid && n < 20);
    chk({name, "_out_valid"}, int'(ifc1.out_valid), 1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, q1.size() + q0.size(), 0);
  endtask

  task automatic run_lit(input string name, input int y, input int u, input int v, input int m,
                         input int r1, input int g1, input int b1,
                         input int r0, input int g0, input int b0);
    int n;
    set_ready(1'b1);
    send(y, u, v, m);
    wait_out(name, n);
    chk({name, "_latency"}, n, 4);
    chk({name, "_R1"}, ifc1.R_out, r1);
    chk({name, "_G1"}, ifc1.G_out, g1);
    chk({name, "_B1"}, ifc1.B_out, b1);
    chk({name, "_R0"}, ifc0.R_out, r0);
    chk({name, "_G0"}, ifc0.G_out, g0);
    chk({name, "_B0"}, ifc0.B_out, b0);
    @(posedge clk); #1;
    wait_drain(name);
  endtask

  // Scoreboard: whenever a result is presented it must equal the oldest expected pixel.
  always @(negedge clk) begin
    if (resetn && !clear) begin
      if (ifc1.out_valid) begin
        if (q1.size() == 0) begin
          chk("sb1_unexpected", 1, 0);
        end else begin
          chk("sb1_R", ifc1.R_out, q1[0].r);
          chk("sb1_G", ifc1.G_out, q1[0].g);
          chk("sb1_B", ifc1.B_out, q1[0].b);
          if (ifc1.out_ready) begin
            void'(q1.pop_front());
            delivered++;
          end
        end
      end
      if (ifc0.out_valid) begin
        if (q0.size() == 0) begin
          chk("sb0_unexpected", 1, 0);
        end else begin
          chk("sb0_R", ifc0.R_out, q0[0].r);
          chk("sb0_G", ifc0.G_out, q0[0].g);
          chk("sb0_B", ifc0.B_out, q0[0].b);
          if (ifc0.out_ready) void'(q0.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   d0;
    rgb_t held;
    resetn = 1'b0;
    clear  = 1'b0;
    drive_in(1'b0, 0, 0, 0, 0);
    set_ready(1'b0);
    #12;
    chk("rst_in_ready", int'(ifc1.in_ready), 1);
    chk("rst_out_valid", int'(ifc1.out_valid), 0);
    chk("rst_R", ifc1.R_out, 0);
    chk("rst_G", ifc1.G_out, 0);
    chk("rst_B", ifc1.B_out, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // T1..T4 with literal expectations (ROUND=1 values, then ROUND=0 values)
    run_lit("t1_black", 16, 128, 128, 0, 0, 0, 0, 0, 0, 0);
    run_lit("t2_white", 235, 128, 128, 0, 255, 255, 255, 254, 254, 254);
    run_lit("t3_clip", 255, 128, 255, 0, 255, 175, 255, 255, 174, 255);
    run_lit("t4_zero", 0, 0, 0, 0, 0, 135, 0, 0, 135, 0);
    run_lit("t4_full", 100, 128, 128, 1, 100, 100, 100, 100, 100, 100);

    // Mixed patterns, both modes, checked by the scoreboard only
    set_ready(1'b1);
    for (int i = 0; i < 8; i++) begin
      send((i * 37 + 5) % 256, (255 - i * 29) % 256, (i * 71 + 3) % 256, i % 2);
    end
    wait_drain("pattern");

    // T5: back-to-back pixels under 10 cycles of backpressure
    set_ready(1'b0);
    send(200, 90, 160, 0);
    send(50, 200, 60, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_in_ready_parked", int'(ifc1.in_ready), 0);
      chk("t5_out_valid_held", int'(ifc1.out_valid), 1);
    end
    @(posedge clk); #1;
    d0 = delivered;
    set_ready(1'b1);
    wait_drain("t5");
    chk("t5_delivered", delivered - d0, 2);
    @(negedge clk);
    chk("t5_no_dup", int'(ifc1.out_valid), 0);
    @(posedge clk); #1;

    // T6: clear in S_V while a result is held
    set_ready(1'b0);
    send(120, 100, 140, 0);
    send(80, 60, 200, 1);
    held = q1[0];
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    q1.delete();
    q0.delete();
    @(negedge clk);
    chk("t6_out_valid", int'(ifc1.out_valid), 0);
    chk("t6_in_ready", int'(ifc1.in_ready), 1);
    chk("t6_R_kept", ifc1.R_out, held.r);
    @(posedge clk); #1;
    run_lit("t6_after", 235, 128, 128, 0, 255, 255, 255, 254, 254, 254);

    // T6b: async reset while parked in S_U
    set_ready(1'b0);
    send(30, 220, 20, 0);
    send(240, 30, 230, 1);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #2;
    chk("rst2_out_valid", int'(ifc1.out_valid), 0);
    chk("rst2_in_ready", int'(ifc1.in_ready), 1);
    chk("rst2_R", ifc1.R_out, 0);
    chk("rst2_G", ifc1.G_out, 0);
    chk("rst2_B", ifc1.B_out, 0);
    chk("rst2_R0", ifc0.R_out, 0);
    q1.delete();
    q0.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_lit("rst2_after", 100, 128, 128, 1, 100, 100, 100, 100, 100, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
